// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: shifts one BUFFER_SIZE-bit frame MSB first and captures the reply.
// All pins and status outputs are registered from the next-state decode.
module spi_frame_master #(
   parameter int BUFFER_SIZE = 240,
   parameter int CLK_DIV     = 4,
   parameter int CS_SETUP    = 2,
   parameter int CS_HOLD     = 2,
   parameter int IDLE_GAP    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [BUFFER_SIZE-1:0] tx_data,
   output logic [BUFFER_SIZE-1:0] rx_data,
   output logic                   busy,
   output logic                   done,
   output logic                   SPI_SCK,
   output logic                   SPI_SSEL,
   output logic                   SPI_MOSI,
   input  logic                   SPI_MISO
);

   localparam int HW   = $clog2(CLK_DIV) + 1;
   localparam int BW   = $clog2(BUFFER_SIZE + 1);
   localparam int WMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                                              : ((CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP);
   localparam int WW   = $clog2(WMAX) + 1;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

   state_t                 state, state_nxt;
   logic [HW-1:0]          hcnt;
   logic [WW-1:0]          wcnt;
   logic [BW-1:0]          bit_cnt;
   logic [BUFFER_SIZE-1:0] tx_shift;
   logic [BUFFER_SIZE-1:0] rx_shift;
   logic                   half_end;
   logic                   wait_end;
   logic                   last_bit;
   logic                   fall_edge;

   assign half_end  = (hcnt == HW'(CLK_DIV - 1));
   assign last_bit  = (bit_cnt >= BW'(BUFFER_SIZE - 1));
   assign fall_edge = (state == SHIFT_HI) && half_end;

   always_comb begin
      wait_end = 1'b0;
      case (state)
         SETUP:   wait_end = (wcnt == WW'(CS_SETUP - 1));
         HOLD:    wait_end = (wcnt == WW'(CS_HOLD - 1));
         GAP:     wait_end = (wcnt == WW'(IDLE_GAP - 1));
         default: wait_end = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start)    state_nxt = SETUP;
         SETUP:    if (wait_end) state_nxt = SHIFT_LO;
         SHIFT_LO: if (half_end) state_nxt = SHIFT_HI;
         SHIFT_HI: if (half_end) state_nxt = last_bit ? HOLD : SHIFT_LO;
         HOLD:     if (wait_end) state_nxt = GAP;
         GAP:      if (wait_end) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Counters restart on every state change, so each phase counts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt <= '0;
         wcnt <= '0;
      end else begin
         if (state_nxt != state || !(state inside {SHIFT_LO, SHIFT_HI})) hcnt <= '0;
         else                                                             hcnt <= hcnt + 1'b1;
         if (state_nxt != state || !(state inside {SETUP, HOLD, GAP}))    wcnt <= '0;
         else                                                             wcnt <= wcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         SPI_SCK  <= 1'b0;
         SPI_SSEL <= 1'b1;
         SPI_MOSI <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
         bit_cnt  <= '0;
      end else begin
         SPI_SCK  <= (state_nxt == SHIFT_HI);
         SPI_SSEL <= (state_nxt == IDLE) || (state_nxt == GAP);
         busy     <= (state_nxt != IDLE);
         done     <= (state == HOLD) && wait_end;
         if (state == IDLE && start) begin
            bit_cnt  <= '0;
            SPI_MOSI <= tx_data[BUFFER_SIZE-1];
         end
         if (fall_edge) begin
            if (bit_cnt != BW'(BUFFER_SIZE)) bit_cnt <= bit_cnt + 1'b1;
            if (!last_bit) SPI_MOSI <= tx_shift[BUFFER_SIZE-2];
         end
         if (state == HOLD && wait_end) begin
            rx_data  <= rx_shift;
            SPI_MOSI <= 1'b0;
         end
      end
   end

   // Shift registers are pure data; they are reloaded on every accepted start.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) tx_shift <= tx_data;
      else if (fall_edge && !last_bit) tx_shift <= {tx_shift[BUFFER_SIZE-2:0], 1'b0};
      if (fall_edge) rx_shift <= {rx_shift[BUFFER_SIZE-2:0], SPI_MISO};
   end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: default 240-bit instance plus a 16-bit CLK_DIV=2 instance.
module tb_spi_frame_master;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [239:0] tx_data = '0;
   logic [239:0] rx_data;
   logic         busy, done, sck, ssel, mosi, miso;
   int           miso_mode = 2;

   logic         s_start = 1'b0;
   logic [15:0]  s_tx = '0;
   logic [15:0]  s_rx;
   logic         s_busy, s_done, s_sck, s_ssel, s_mosi;
   logic         s_miso = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

   spi_frame_master dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
      .busy(busy), .done(done), .SPI_SCK(sck), .SPI_SSEL(ssel), .SPI_MOSI(mosi), .SPI_MISO(miso)
   );

   spi_frame_master #(.BUFFER_SIZE(16), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(4)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .tx_data(s_tx), .rx_data(s_rx),
      .busy(s_busy), .done(s_done), .SPI_SCK(s_sck), .SPI_SSEL(s_ssel), .SPI_MOSI(s_mosi),
      .SPI_MISO(s_miso)
   );

   typedef struct {
      logic [239:0] tx;
      int           mode;
      logic [239:0] exp_rx;
      int           pulse_a;
      int           pulse_b;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [239:0] act, input logic [239:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      int dcyc, nd, edges;
      logic prev;
      dcyc = -1; nd = 0; edges = 0; prev = 1'b0;
      @(negedge clk);
      miso_mode = v.mode;
      tx_data   = v.tx;
      start     = 1'b1;
      for (int n = 1; n <= 1935; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk($sformatf("v%0d ssel_c1", idx), 240'(ssel), 240'(0));
            chk($sformatf("v%0d busy_c1", idx), 240'(busy), 240'(1));
            chk($sformatf("v%0d mosi_c1", idx), 240'(mosi), 240'(v.tx[239]));
         end
         if (sck && !prev) edges++;
         prev = sck;
         if (done) begin nd++; dcyc = n; end
         if (n == 1928) chk($sformatf("v%0d busy_c1928", idx), 240'(busy), 240'(1));
         if (n == 1930) begin
            chk($sformatf("v%0d busy_c1930", idx), 240'(busy), 240'(0));
            chk($sformatf("v%0d ssel_c1930", idx), 240'(ssel), 240'(1));
         end
         if (n == 5) tx_data = ~v.tx;
         start = (n == v.pulse_a) || (n == v.pulse_b);
      end
      start = 1'b0;
      chk($sformatf("v%0d done_cycle", idx), 240'(dcyc), 240'(1925));
      chk($sformatf("v%0d done_count", idx), 240'(nd), 240'(1));
      chk($sformatf("v%0d sck_rises", idx), 240'(edges), 240'(240));
      chk($sformatf("v%0d rx_data", idx), rx_data, v.exp_rx);
   endtask

   task automatic run_small(input logic miso_val, input logic [15:0] exp_rx);
      int dcyc, edges, first, second;
      logic prev;
      dcyc = -1; edges = 0; first = -1; second = -1; prev = 1'b0;
      @(negedge clk);
      s_miso  = miso_val;
      s_tx    = 16'h1234;
      s_start = 1'b1;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (s_sck && !prev) begin
            edges++;
            if (first < 0) first = n;
            else if (second < 0) second = n;
         end
         prev = s_sck;
         if (s_done) dcyc = n;
      end
      chk("small done_cycle", 240'(dcyc), 240'(69));
      chk("small sck_rises", 240'(edges), 240'(16));
      chk("small sck_period", 240'(second - first), 240'(4));
      chk("small rx_data", 240'(s_rx), 240'(exp_rx));
   endtask

   initial begin
      int nd, dcyc;
      vecs[0] = '{tx: {30{8'hA5}}, mode: 0, exp_rx: {30{8'hA5}}, pulse_a: -1, pulse_b: -1};
      vecs[1] = '{tx: {16'hF00D, 208'h0, 16'h0001}, mode: 0, exp_rx: {16'hF00D, 208'h0, 16'h0001},
                  pulse_a: 50, pulse_b: 1926};
      vecs[2] = '{tx: {240{1'b1}}, mode: 2, exp_rx: 240'h0, pulse_a: -1, pulse_b: -1};
      vecs[3] = '{tx: {30{8'h3C}}, mode: 1, exp_rx: {240{1'b1}}, pulse_a: -1, pulse_b: -1};

      repeat (3) @(negedge clk);
      chk("reset sck", 240'(sck), 240'(0));
      chk("reset ssel", 240'(ssel), 240'(1));
      chk("reset mosi", 240'(mosi), 240'(0));
      chk("reset busy", 240'(busy), 240'(0));
      chk("reset done", 240'(done), 240'(0));
      chk("reset rx_data", rx_data, 240'h0);
      chk("reset small ssel", 240'(s_ssel), 240'(1));
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_frame(vecs[i], i);

      // Reset mid-frame, with start held high during the reset cycle.
      nd = 0;
      @(negedge clk);
      miso_mode = 0;
      tx_data   = {30{8'hA5}};
      start     = 1'b1;
      for (int n = 1; n <= 600; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) nd++;
         if (n == 600) begin
            chk("pre_rst sck_high", 240'(sck), 240'(1));
            rst   = 1'b1;
            start = 1'b1;
         end
      end
      @(negedge clk);
      chk("rst no_done", 240'(nd), 240'(0));
      chk("rst ssel", 240'(ssel), 240'(1));
      chk("rst sck", 240'(sck), 240'(0));
      chk("rst rx_data", rx_data, 240'h0);
      chk("rst busy", 240'(busy), 240'(0));
      chk("rst done", 240'(done), 240'(0));
      rst   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("post_rst ssel", 240'(ssel), 240'(0));
      chk("post_rst busy", 240'(busy), 240'(1));
      dcyc = -1;
      for (int n = 2; n <= 2000 && dcyc < 0; n++) begin
         @(negedge clk);
         if (done) dcyc = n;
      end
      chk("post_rst done_cycle", 240'(dcyc), 240'(1925));
      chk("post_rst rx_data", rx_data, {30{8'hA5}});
      repeat (10) @(negedge clk);

      run_small(1'b1, 16'hFFFF);
      run_small(1'b0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
